bit_serial_alu_ctrl: RTL and testbench

- Sequencer that computes a WIDTH-bit ALU operation (add, sub, and, or) by time-multiplexing one instance of the existing 1-bit ALU slice, LSB first, one bit per clock.
- Holds the operands, steps a bit counter and carries the slice's carryOut into the next cycle's carryIn through a flip-flop.
- Assembles the result and produces N/Z/C/V flags.
- Used where area matters more than latency; sits between the register-file read ports and writeback.

---
 rtl/bit_serial_alu_ctrl.sv | 124 ++++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs one 1-bit ALU slice LSB-first over WIDTH cycles,
// chaining carry through a flop, then presents the assembled result and N/Z/C/V flags.
module bit_serial_alu_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       ALUControl,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-2:0] sh_q, sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;

    logic             bit_a, bit_b, bit_bx;
    logic             slice_res, slice_cout;
    logic [WIDTH-1:0] final_res;
    logic             arith;

    // 1-bit ALU slice
    always_comb begin
        bit_a      = a_q[cnt_q];
        bit_b      = b_q[cnt_q];
        bit_bx     = bit_b ^ op_q[0];
        slice_cout = (bit_a & bit_bx) | (carry_q & (bit_a ^ bit_bx));
        case (op_q)
            2'b10:   slice_res = bit_a & bit_b;
            2'b11:   slice_res = bit_a | bit_b;
            default: slice_res = bit_a ^ bit_bx ^ carry_q;
        endcase
    end

    // sh_q holds the WIDTH-1 most recent slice bits; the current bit completes the word
    assign final_res = {slice_res, sh_q};
    assign arith     = ~op_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sh_d    = sh_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = ALUControl;
                    cnt_d   = '0;
                    carry_d = ALUControl[0];
                    state_d = StRun;
                end
            end
            StRun: begin
                sh_d    = final_res[WIDTH-1:1];
                carry_d = slice_cout;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    res_d   = final_res;
                    flags_d = {final_res[WIDTH-1],
                               final_res == '0,
                               arith & slice_cout,
                               arith & ~(op_q[0] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1])
                                     & (a_q[WIDTH-1] ^ final_res[WIDTH-1])};
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            sh_q    <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign ready    = (state_q == StIdle);
    assign done     = (state_q == StDone);
    assign Result   = res_q;
    assign ALUFlags = flags_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed bench for bit_serial_alu_ctrl: 8-bit instance for function/control checks,
// 32-bit instance for back-to-back throughput.
module tb_bit_serial_alu_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [1:0]  op8;
    logic        ready8, done8;
    logic [7:0]  res8;
    logic [3:0]  fl8;

    logic        start32;
    logic [31:0] a32, b32;
    logic [1:0]  op32;
    logic        ready32, done32;
    logic [31:0] res32;
    logic [3:0]  fl32;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int dones8 = 0;

    bit_serial_alu_ctrl #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .ALUControl (op8),
        .ready      (ready8),
        .done       (done8),
        .Result     (res8),
        .ALUFlags   (fl8)
    );

    bit_serial_alu_ctrl #(.WIDTH(32)) u_dut32 (
        .clk        (clk),
        .reset      (reset),
        .start      (start32),
        .a          (a32),
        .b          (b32),
        .ALUControl (op32),
        .ready      (ready32),
        .done       (done32),
        .Result     (res32),
        .ALUFlags   (fl32)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done8) dones8 <= dones8 + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue8(input logic [7:0] aa, input logic [7:0] bb, input logic [1:0] op);
        @(negedge clk);
        a8 = aa; b8 = bb; op8 = op; start8 = 1'b1;
        @(posedge clk);
        #1;
        // scramble operands after acceptance; they must have no effect
        start8 = 1'b0; a8 = ~aa; b8 = ~bb; op8 = ~op;
    endtask

    task automatic issue32(input logic [31:0] aa, input logic [31:0] bb, input logic [1:0] op);
        @(negedge clk);
        a32 = aa; b32 = bb; op32 = op; start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0; a32 = ~aa; b32 = ~bb; op32 = ~op;
    endtask

    task automatic wait_done8(output int lat);
        lat = 0;
        while (!done8 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_done32(output int lat);
        lat = 0;
        while (!done32 && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic do_op8(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                          input logic [1:0] op, input logic [7:0] er, input logic [3:0] ef);
        int lat;
        issue8(aa, bb, op);
        wait_done8(lat);
        check({tag, " latency"}, lat, 8);
        check({tag, " ready low in done"}, ready8, 1'b0);
        check({tag, " result"}, res8, er);
        check({tag, " flags"}, fl8, ef);
        @(posedge clk);
        #1;
        check({tag, " done/ready after"}, {done8, ready8}, 2'b01);
    endtask

    initial begin
        int lat, d0, t1, t2;
        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        start32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
        #12;
        check("reset ready8", ready8, 1'b1);
        check("reset done8", done8, 1'b0);
        check("reset result8", res8, 8'h00);
        check("reset flags8", fl8, 4'h0);
        check("reset ready32", ready32, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        do_op8("add ovf", 8'h7F, 8'h01, 2'b00, 8'h80, 4'b1001);
        do_op8("sub eq",  8'h05, 8'h05, 2'b01, 8'h00, 4'b0110);
        do_op8("sub neg", 8'h03, 8'h05, 2'b01, 8'hFE, 4'b1000);
        do_op8("and",     8'hF0, 8'h3C, 2'b10, 8'h30, 4'b0000);
        do_op8("or",      8'hF0, 8'h3C, 2'b11, 8'hFC, 4'b1000);

        // Busy rejection: start pulses during RUN and in the DONE cycle are ignored
        d0 = dones8;
        issue8(8'h01, 8'h01, 2'b00);
        repeat (3) @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; op8 = 2'b00;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(lat);
        check("busy done seen", done8, 1'b1);
        check("busy result", res8, 8'h02);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
        @(posedge clk);
        #1;
        check("busy idle after done", ready8, 1'b1);
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("busy no second op", ready8, 1'b1);
        check("busy one done pulse", dones8 - d0, 1);
        check("busy result held", res8, 8'h02);

        // Reset mid-operation
        issue8(8'h10, 8'h20, 2'b00);
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst ready", ready8, 1'b1);
        check("midrst result", res8, 8'h00);
        check("midrst flags", fl8, 4'h0);
        d0 = dones8;
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("midrst no done", dones8 - d0, 0);
        do_op8("post rst add", 8'hFF, 8'h01, 2'b00, 8'h00, 4'b0110);

        // WIDTH=32 back-to-back
        issue32(32'hFFFF_FFFF, 32'h0000_0001, 2'b00);
        wait_done32(lat);
        t1 = cyc;
        check("w32 first latency", lat, 32);
        check("w32 first result", res32, 32'h0000_0000);
        check("w32 first flags", fl32, 4'b0110);
        @(posedge clk);
        #1;
        check("w32 ready after first", ready32, 1'b1);
        issue32(32'h8000_0000, 32'h0000_0001, 2'b01);
        wait_done32(lat);
        t2 = cyc;
        check("w32 second done seen", done32, 1'b1);
        check("w32 done spacing", t2 - t1, 34);
        check("w32 second result", res32, 32'h7FFF_FFFF);
        check("w32 second flags", fl32, 4'b0011);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
